// File: rtl/fan_off_timer_ctrl_pkg.sv
// Shared definitions for the fan off-timer: state encoding and the preset table
// (BCD minutes per preset index).
package fan_timer_defs;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_PAUSE = 2'd3;

  localparam logic [2:0] PRESET_LAST = 3'd6;

  // BCD minutes for each preset; index 0 means no timer
  function automatic logic [7:0] preset_bcd(input logic [2:0] idx);
    logic [7:0] m;
    case (idx)
      3'd1:    m = 8'h01;
      3'd2:    m = 8'h03;
      3'd3:    m = 8'h05;
      3'd4:    m = 8'h10;
      3'd5:    m = 8'h30;
      3'd6:    m = 8'h60;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/fan_bcd_dn_digit.sv
// One loadable BCD down-counting digit; wraps to reload_val and raises borrow
// when decremented from 0.
module fan_bcd_dn_digit (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  input  logic [3:0] reload_val,
  output logic [3:0] digit,
  output logic       borrow
);

  logic [3:0] digit_q, digit_d;

  // next digit value: load wins over decrement
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (dec) begin
      if (digit_q == 4'd0) begin
        digit_d = reload_val;
      end else begin
        digit_d = digit_q - 4'd1;
      end
    end else begin
      digit_d = digit_q;
    end
  end

  // digit register
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit  = digit_q;
  assign borrow = dec & (digit_q == 4'd0);

endmodule

// File: rtl/fan_off_timer_ctrl.sv
// Fan off-timer: preset selection, start/pause/cancel FSM and an mm:ss BCD
// countdown paced by the 1 s tick, with a one-cycle done pulse on expiry.
module fan_off_timer_ctrl
  import fan_timer_defs::*;
#(
  parameter int SEC_PER_MIN = 60
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       tick_sec,
  input  logic       btn_set,
  input  logic       btn_start,
  input  logic       btn_cancel,
  output logic [2:0] preset_sel,
  output logic [3:0] min_10,
  output logic [3:0] min_1,
  output logic [3:0] sec_10,
  output logic [3:0] sec_1,
  output logic       timer_armed,
  output logic       timer_running,
  output logic       done
);

  localparam logic [3:0] SEC10_TOP = 4'((SEC_PER_MIN - 1) / 10);
  localparam logic [3:0] SEC1_TOP  = 4'((SEC_PER_MIN - 1) % 10);

  logic [1:0]  state_q, state_d;
  logic [2:0]  preset_q, preset_d;
  logic        done_q, done_d;
  logic        armed_q, running_q;
  logic        load_s, dec_s, at_one_s;
  logic [15:0] load_val_s;
  logic [3:0]  sec1_reload_s;
  logic        b_sec1_s, b_sec10_s, b_min1_s, unused_borrow_s;

  assign at_one_s = ({min_10, min_1, sec_10, sec_1} == 16'h0001);
  // units of seconds only wrap to the short top value when the whole seconds field is 00
  assign sec1_reload_s = (sec_10 == 4'd0) ? SEC1_TOP : 4'd9;

  // event priority and FSM next-state: cancel > start > set > tick
  always_comb begin
    state_d    = state_q;
    preset_d   = preset_q;
    done_d     = 1'b0;
    load_s     = 1'b0;
    load_val_s = 16'h0000;
    dec_s      = 1'b0;
    if (btn_cancel) begin
      state_d  = ST_IDLE;
      preset_d = 3'd0;
      load_s   = 1'b1;
    end else if (btn_start) begin
      case (state_q)
        ST_ARMED: state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = state_q;
      endcase
    end else if (btn_set) begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_ARMED;
          preset_d   = 3'd1;
          load_s     = 1'b1;
          load_val_s = {preset_bcd(3'd1), 8'h00};
        end
        ST_ARMED: begin
          load_s = 1'b1;
          if (preset_q == PRESET_LAST) begin
            state_d  = ST_IDLE;
            preset_d = 3'd0;
          end else begin
            preset_d   = preset_q + 3'd1;
            load_val_s = {preset_bcd(preset_q + 3'd1), 8'h00};
          end
        end
        default: state_d = state_q;
      endcase
    end else if (tick_sec && (state_q == ST_RUN)) begin
      if (at_one_s) begin
        state_d  = ST_IDLE;
        preset_d = 3'd0;
        done_d   = 1'b1;
        load_s   = 1'b1;
      end else begin
        dec_s = 1'b1;
      end
    end else begin
      state_d = state_q;
    end
  end

  // control registers; status flags follow the next state so they line up with the digits
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q   <= ST_IDLE;
      preset_q  <= 3'd0;
      done_q    <= 1'b0;
      armed_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      preset_q  <= preset_d;
      done_q    <= done_d;
      armed_q   <= (state_d != ST_IDLE);
      running_q <= (state_d == ST_RUN);
    end
  end

  fan_bcd_dn_digit u_sec_1 (
    .clk(clk), .reset_p(reset_p), .load(load_s), .load_val(load_val_s[3:0]),
    .dec(dec_s), .reload_val(sec1_reload_s), .digit(sec_1), .borrow(b_sec1_s)
  );

  fan_bcd_dn_digit u_sec_10 (
    .clk(clk), .reset_p(reset_p), .load(load_s), .load_val(load_val_s[7:4]),
    .dec(b_sec1_s), .reload_val(SEC10_TOP), .digit(sec_10), .borrow(b_sec10_s)
  );

  fan_bcd_dn_digit u_min_1 (
    .clk(clk), .reset_p(reset_p), .load(load_s), .load_val(load_val_s[11:8]),
    .dec(b_sec10_s), .reload_val(4'd9), .digit(min_1), .borrow(b_min1_s)
  );

  // the 00:01 expiry path keeps this top borrow from ever firing
  fan_bcd_dn_digit u_min_10 (
    .clk(clk), .reset_p(reset_p), .load(load_s), .load_val(load_val_s[15:12]),
    .dec(b_min1_s), .reload_val(4'd9), .digit(min_10), .borrow(unused_borrow_s)
  );

  assign preset_sel    = preset_q;
  assign done          = done_q;
  assign timer_armed   = armed_q;
  assign timer_running = running_q;

endmodule

// File: tb/tb_fan_off_timer_ctrl.sv
// Directed bench for fan_off_timer_ctrl: two instances (60 s and 10 s minutes)
// share stimulus; a seconds-based model feeds a scoreboard queue.
module tb_fan_off_timer_ctrl;

  logic clk = 1'b0;
  logic reset_p, tick_sec, btn_set, btn_start, btn_cancel;

  logic [2:0] ps_a, ps_b;
  logic [3:0] m10_a, m1_a, s10_a, s1_a, m10_b, m1_b, s10_b, s1_b;
  logic       arm_a, run_a, done_a, arm_b, run_b, done_b;
  logic [21:0] obs_a, obs_b;

  fan_off_timer_ctrl #(.SEC_PER_MIN(60)) dut_a (
    .clk(clk), .reset_p(reset_p), .tick_sec(tick_sec), .btn_set(btn_set),
    .btn_start(btn_start), .btn_cancel(btn_cancel), .preset_sel(ps_a),
    .min_10(m10_a), .min_1(m1_a), .sec_10(s10_a), .sec_1(s1_a),
    .timer_armed(arm_a), .timer_running(run_a), .done(done_a)
  );

  fan_off_timer_ctrl #(.SEC_PER_MIN(10)) dut_b (
    .clk(clk), .reset_p(reset_p), .tick_sec(tick_sec), .btn_set(btn_set),
    .btn_start(btn_start), .btn_cancel(btn_cancel), .preset_sel(ps_b),
    .min_10(m10_b), .min_1(m1_b), .sec_10(s10_b), .sec_1(s1_b),
    .timer_armed(arm_b), .timer_running(run_b), .done(done_b)
  );

  assign obs_a = {ps_a, m10_a, m1_a, s10_a, s1_a, arm_a, run_a, done_a};
  assign obs_b = {ps_b, m10_b, m1_b, s10_b, s1_b, arm_b, run_b, done_b};

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [21:0] e0;
    logic [21:0] e1;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;

  // model: 0 idle, 1 armed, 2 run, 3 pause; time held as total seconds
  int preset_min [7] = '{0, 1, 3, 5, 10, 30, 60};
  int m_st [2];
  int m_idx [2];
  int m_rem [2];
  int m_done [2];

  function automatic int spm(input int u);
    return (u == 0) ? 60 : 10;
  endfunction

  function automatic logic [21:0] exp_vec(input int u);
    int mm, ss;
    logic a, r, d;
    mm = m_rem[u] / spm(u);
    ss = m_rem[u] % spm(u);
    a = (m_st[u] != 0);
    r = (m_st[u] == 2);
    d = (m_done[u] != 0);
    return {3'(m_idx[u]), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), a, r, d};
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_st[u] = 0; m_idx[u] = 0; m_rem[u] = 0; m_done[u] = 0;
    end
  endtask

  task automatic model_step(input bit s, input bit st, input bit c, input bit t);
    for (int u = 0; u < 2; u++) begin
      m_done[u] = 0;
      if (c) begin
        m_st[u] = 0; m_idx[u] = 0; m_rem[u] = 0;
      end else if (st) begin
        if (m_st[u] == 1 || m_st[u] == 3) m_st[u] = 2;
        else if (m_st[u] == 2) m_st[u] = 3;
      end else if (s) begin
        if (m_st[u] == 0) begin
          m_st[u] = 1; m_idx[u] = 1; m_rem[u] = preset_min[1] * spm(u);
        end else if (m_st[u] == 1) begin
          if (m_idx[u] == 6) begin
            m_st[u] = 0; m_idx[u] = 0; m_rem[u] = 0;
          end else begin
            m_idx[u] = m_idx[u] + 1;
            m_rem[u] = preset_min[m_idx[u]] * spm(u);
          end
        end
      end else if (t && m_st[u] == 2) begin
        m_rem[u] = m_rem[u] - 1;
        if (m_rem[u] == 0) begin
          m_st[u] = 0; m_idx[u] = 0; m_done[u] = 1;
        end
      end
    end
  endtask

  task automatic push(input string tag);
    exp_t e;
    e.tag = tag;
    e.e0 = exp_vec(0);
    e.e1 = exp_vec(1);
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL sb_empty obs_a=%h", obs_a);
    end else begin
      e = sb_q.pop_front();
      assert (obs_a === e.e0) else begin
        failures++;
        $error("FAIL %s spm60 obs=%h exp=%h", e.tag, obs_a, e.e0);
      end
      checks++;
      assert (obs_b === e.e1) else begin
        failures++;
        $error("FAIL %s spm10 obs=%h exp=%h", e.tag, obs_b, e.e1);
      end
    end
  endtask

  // one cycle of stimulus, driven and checked on the falling edge
  task automatic cyc(input bit s, input bit st, input bit c, input bit t, input string tag);
    btn_set = s; btn_start = st; btn_cancel = c; tick_sec = t;
    model_step(s, st, c, t);
    push(tag);
    @(posedge clk);
    #1;
    btn_set = 1'b0; btn_start = 1'b0; btn_cancel = 1'b0; tick_sec = 1'b0;
    @(negedge clk);
    pop_check();
  endtask

  initial begin
    reset_p = 1'b1;
    tick_sec = 1'b0; btn_set = 1'b0; btn_start = 1'b0; btn_cancel = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    push("reset");
    pop_check();
    @(negedge clk);
    reset_p = 1'b0;

    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, $sformatf("set_%0d", i + 1));
    for (int i = 3; i < 7; i++) cyc(1, 0, 0, 0, $sformatf("set_%0d", i + 1));
    cyc(0, 1, 0, 0, "start_idle");

    cyc(1, 0, 0, 0, "p1_set");
    cyc(0, 1, 0, 0, "p1_start");
    for (int i = 0; i < 60; i++) cyc(0, 0, 0, 1, $sformatf("p1_tick_%0d", i + 1));
    cyc(0, 0, 0, 0, "post_done");

    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, "p3_set");
    cyc(0, 1, 0, 1, "p3_start_tick");
    cyc(0, 0, 0, 1, "p3_first_tick");
    cyc(0, 0, 1, 0, "p3_cancel");

    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, "p4_set");
    cyc(0, 1, 0, 0, "p4_start");
    cyc(0, 0, 0, 1, "borrow_chain");
    cyc(0, 0, 1, 0, "p4_cancel");

    cyc(1, 0, 0, 0, "p2_set");
    cyc(1, 0, 0, 0, "p2_set");
    cyc(0, 1, 0, 0, "p2_start");
    for (int i = 0; i < 30; i++) cyc(0, 0, 0, 1, "p2_tick");
    cyc(0, 1, 0, 0, "pause");
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, "pause_hold");
    cyc(1, 0, 0, 1, "pause_set_tick");
    cyc(0, 1, 0, 0, "resume");
    cyc(0, 0, 0, 1, "resume_tick");
    cyc(0, 1, 0, 1, "start_tick_run");
    cyc(0, 1, 0, 0, "resume2");
    cyc(1, 0, 0, 1, "run_set_tick");
    cyc(0, 0, 1, 0, "p2_cancel");

    cyc(1, 0, 0, 0, "c1_set");
    cyc(0, 1, 0, 0, "c1_start");
    for (int i = 0; i < 59; i++) cyc(0, 0, 0, 1, "c1_tick");
    cyc(0, 0, 1, 1, "cancel_at_one");
    cyc(0, 0, 0, 0, "cancel_after");

    cyc(1, 0, 0, 0, "r_set");
    cyc(1, 0, 0, 0, "r_set");
    cyc(0, 1, 0, 0, "r_start");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, "r_tick");
    #2;
    reset_p = 1'b1;
    model_reset();
    push("async_reset");
    #1;
    pop_check();
    @(negedge clk);
    reset_p = 1'b0;
    cyc(0, 0, 0, 1, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
